// File: rtl/pokey_clk_enable_gen.sv
// Multi-channel fractional clock-enable generator for the PLL GENCLK domain.
// Each channel runs a phase accumulator. The carry out of the accumulator
// becomes a registered single-cycle enable pulse. All enables are held off
// until a synchronised PLL LOCK has stayed high for LOCK_WAIT cycles.
//
// Ports:
//   CLK       PLL output clock
//   RESET     synchronous, active-high reset
//   PLL_LOCK  raw PLL lock, asynchronous to CLK
//   INC_WR    one-cycle strobe that loads INC_DATA into channel INC_CH
//   INC_CH    target channel for INC_WR; out-of-range channels are ignored
//   INC_DATA  new phase increment
//   CE        one-cycle clock-enable pulses, one bit per channel
//   READY     high while the generator is running
module pokey_clk_enable_gen #(
    parameter int unsigned              NUM_CH    = 3,
    parameter int unsigned              ACC_W     = 24,
    parameter logic [NUM_CH*ACC_W-1:0]  INC_INIT  = '0,
    parameter int unsigned              LOCK_WAIT = 1024
) (
    input  logic                                            CLK,
    input  logic                                            RESET,
    input  logic                                            PLL_LOCK,
    input  logic                                            INC_WR,
    input  logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0]  INC_CH,
    input  logic [ACC_W-1:0]                                INC_DATA,
    output logic [NUM_CH-1:0]                               CE,
    output logic                                            READY
);

    localparam int unsigned CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int unsigned CNT_W = (LOCK_WAIT > 1) ? $clog2(LOCK_WAIT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOCK_WAIT - 1);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_LOCK = 2'd1,
        RUN       = 2'd2
    } state_t;

    state_t             state;
    state_t             state_next;
    logic               sync1;
    logic               lock_s;
    logic [CNT_W-1:0]   cnt;
    logic [CNT_W-1:0]   cnt_next;
    logic [ACC_W-1:0]   acc      [NUM_CH];
    logic [ACC_W-1:0]   acc_next [NUM_CH];
    logic [ACC_W-1:0]   inc      [NUM_CH];
    logic [ACC_W-1:0]   inc_next [NUM_CH];
    logic [ACC_W:0]     sum      [NUM_CH];
    logic [NUM_CH-1:0]  ce;
    logic [NUM_CH-1:0]  ce_next;
    logic               ready;
    logic               ready_next;

    // Per-channel add with carry out in the top bit.
    for (genvar n = 0; n < NUM_CH; n++) begin : g_sum
        assign sum[n] = {1'b0, acc[n]} + {1'b0, inc[n]};
    end

    // Next-state, accumulator, and increment-update logic.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        ce_next    = '0;
        ready_next = 1'b0;
        for (int unsigned n = 0; n < NUM_CH; n++) begin
            acc_next[n] = '0;
            inc_next[n] = inc[n];
        end

        case (state)
            IDLE: begin
                state_next = WAIT_LOCK;
            end
            WAIT_LOCK: begin
                if (!lock_s) begin
                    cnt_next = '0;
                end else if (cnt == CNT_LAST) begin
                    state_next = RUN;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt + CNT_W'(1);
                end
            end
            RUN: begin
                if (!lock_s) begin
                    // Lock lost: accumulators and enables stay at their cleared defaults.
                    state_next = WAIT_LOCK;
                    cnt_next   = '0;
                end else begin
                    for (int unsigned n = 0; n < NUM_CH; n++) begin
                        acc_next[n] = sum[n][ACC_W-1:0];
                        ce_next[n]  = sum[n][ACC_W];
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        // Matching by loop index rejects out-of-range channels without side effects.
        if (INC_WR) begin
            for (int unsigned n = 0; n < NUM_CH; n++) begin
                if (INC_CH == CH_W'(n)) begin
                    inc_next[n] = INC_DATA;
                end
            end
        end

        ready_next = (state_next == RUN);
    end

    // State, synchroniser, and datapath registers.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state  <= IDLE;
            sync1  <= 1'b0;
            lock_s <= 1'b0;
            cnt    <= '0;
            ce     <= '0;
            ready  <= 1'b0;
            for (int unsigned n = 0; n < NUM_CH; n++) begin
                acc[n] <= '0;
                inc[n] <= INC_INIT[n*ACC_W +: ACC_W];
            end
        end else begin
            state  <= state_next;
            sync1  <= PLL_LOCK;
            lock_s <= sync1;
            cnt    <= cnt_next;
            ce     <= ce_next;
            ready  <= ready_next;
            for (int unsigned n = 0; n < NUM_CH; n++) begin
                acc[n] <= acc_next[n];
                inc[n] <= inc_next[n];
            end
        end
    end

    assign CE    = ce;
    assign READY = ready;

endmodule

// File: tb/tb_pokey_clk_enable_gen.sv
// Self-checking bench for pokey_clk_enable_gen (3 channels, 8-bit accumulators,
// LOCK_WAIT=4). A behavioural reference model pushes expected {READY,CE}
// after every clock edge; a checker pops and compares on the falling edge.
// Scenario tasks add their own latency, rate and gap checks.
module tb_pokey_clk_enable_gen;

    localparam int unsigned NUM_CH    = 3;
    localparam int unsigned ACC_W     = 8;
    localparam int unsigned LOCK_WAIT = 4;
    localparam logic [NUM_CH*ACC_W-1:0] INC_INIT = {8'd0, 8'd96, 8'd64};

    logic               CLK = 1'b0;
    logic               RESET = 1'b1;
    logic               PLL_LOCK = 1'b0;
    logic               INC_WR = 1'b0;
    logic [1:0]         INC_CH = 2'd0;
    logic [ACC_W-1:0]   INC_DATA = '0;
    logic [NUM_CH-1:0]  CE;
    logic               READY;

    int total = 0;
    int bad   = 0;

    pokey_clk_enable_gen #(
        .NUM_CH    (NUM_CH),
        .ACC_W     (ACC_W),
        .INC_INIT  (INC_INIT),
        .LOCK_WAIT (LOCK_WAIT)
    ) dut (
        .CLK      (CLK),
        .RESET    (RESET),
        .PLL_LOCK (PLL_LOCK),
        .INC_WR   (INC_WR),
        .INC_CH   (INC_CH),
        .INC_DATA (INC_DATA),
        .CE       (CE),
        .READY    (READY)
    );

    always #5 CLK = ~CLK;

    // ---------------- reference model + scoreboard ----------------
    logic [3:0] exp_q [$];

    int         m_state = 0;      // 0 idle, 1 waiting for lock, 2 running
    bit         m_s1 = 1'b0;
    bit         m_ls = 1'b0;
    int         m_cnt = 0;
    int         m_phase [NUM_CH];
    int         m_inc   [NUM_CH];
    bit [2:0]   m_ce = 3'b000;
    bit         m_ready = 1'b0;
    bit         m_adv;

    always @(posedge CLK) begin
        if (RESET) begin
            m_state = 0;
            m_s1 = 1'b0;
            m_ls = 1'b0;
            m_cnt = 0;
            m_ce = 3'b000;
            m_ready = 1'b0;
            m_inc[0] = 64;
            m_inc[1] = 96;
            m_inc[2] = 0;
            for (int n = 0; n < NUM_CH; n++) m_phase[n] = 0;
        end else begin
            m_adv = (m_state == 2) && m_ls;
            for (int n = 0; n < NUM_CH; n++) begin
                if (m_adv) begin
                    m_phase[n] = m_phase[n] + m_inc[n];
                    if (m_phase[n] >= 256) begin
                        m_phase[n] = m_phase[n] - 256;
                        m_ce[n] = 1'b1;
                    end else begin
                        m_ce[n] = 1'b0;
                    end
                end else begin
                    m_phase[n] = 0;
                    m_ce[n] = 1'b0;
                end
            end
            if (m_state == 0) begin
                m_state = 1;
            end else if (m_state == 1) begin
                if (!m_ls) m_cnt = 0;
                else if (m_cnt == LOCK_WAIT - 1) begin
                    m_state = 2;
                    m_cnt = 0;
                end else m_cnt = m_cnt + 1;
            end else if (!m_ls) begin
                m_state = 1;
                m_cnt = 0;
            end
            if (INC_WR && (INC_CH < 2'd3)) m_inc[INC_CH] = int'(INC_DATA);
            m_ls = m_s1;
            m_s1 = PLL_LOCK;
            m_ready = (m_state == 2);
        end
        exp_q.push_back({m_ready, m_ce});
    end

    logic [3:0] exp_v;
    always @(negedge CLK) begin
        if (exp_q.size() > 0) begin
            exp_v = exp_q.pop_front();
            total++;
            if ({READY, CE} !== exp_v) begin
                bad++;
                $display("FAIL scoreboard t=%0t: {READY,CE} got %b expected %b", $time, {READY, CE}, exp_v);
            end
        end
    end

    // ---------------- scenarios ----------------
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        RESET = 1'b1;
        tick();
        tick();
        total++;
        if (CE !== 3'b000) begin
            bad++;
            $display("FAIL reset_ce: got %b expected 000", CE);
        end
        total++;
        if (READY !== 1'b0) begin
            bad++;
            $display("FAIL reset_ready: got %b expected 0", READY);
        end
    endtask

    task automatic test_lock_ready();
        int n;
        int last;
        int pulses;
        int gapbad;
        RESET = 1'b0;
        PLL_LOCK = 1'b0;
        repeat (8) tick();
        total++;
        if (READY !== 1'b0) begin
            bad++;
            $display("FAIL ready_without_lock: got %b expected 0", READY);
        end
        PLL_LOCK = 1'b1;
        n = 0;
        while (READY !== 1'b1 && n < 30) begin
            tick();
            n++;
        end
        total++;
        if (n != 6) begin
            bad++;
            $display("FAIL lock_latency: got %0d cycles expected 6", n);
        end
        last = -1;
        pulses = 0;
        gapbad = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (CE[0]) begin
                if (last >= 0 && (i - last) != 4) gapbad++;
                last = i;
                pulses++;
            end
        end
        total++;
        if (pulses != 10 || gapbad != 0) begin
            bad++;
            $display("FAIL ch0_period4: got pulses=%0d badgaps=%0d expected pulses=10 badgaps=0", pulses, gapbad);
        end
    endtask

    task automatic test_rate_ch1();
        int c0;
        int c1;
        int last;
        int gapbad;
        c0 = 0;
        c1 = 0;
        last = -1;
        gapbad = 0;
        for (int i = 0; i < 256; i++) begin
            tick();
            if (CE[0]) c0++;
            if (CE[1]) begin
                if (last >= 0 && (i - last) != 2 && (i - last) != 3) gapbad++;
                last = i;
                c1++;
            end
        end
        total++;
        if (c1 != 96) begin
            bad++;
            $display("FAIL ch1_count: got %0d expected 96", c1);
        end
        total++;
        if (gapbad != 0) begin
            bad++;
            $display("FAIL ch1_gaps: got %0d bad gaps expected 0", gapbad);
        end
        total++;
        if (c0 != 64) begin
            bad++;
            $display("FAIL ch0_count: got %0d expected 64", c0);
        end
    endtask

    task automatic test_lock_drop();
        int n;
        PLL_LOCK = 1'b0;
        tick();
        PLL_LOCK = 1'b1;
        tick();
        // Write lands on the same edge that sees the lost lock.
        INC_WR = 1'b1;
        INC_CH = 2'd1;
        INC_DATA = 8'd80;
        tick();
        INC_WR = 1'b0;
        total++;
        if (READY !== 1'b0 || CE !== 3'b000) begin
            bad++;
            $display("FAIL lock_drop: got READY=%b CE=%b expected READY=0 CE=000", READY, CE);
        end
        n = 0;
        while (READY !== 1'b1 && n < 30) begin
            tick();
            n++;
        end
        total++;
        if (n != LOCK_WAIT) begin
            bad++;
            $display("FAIL relock_latency: got %0d cycles expected %0d", n, LOCK_WAIT);
        end
        n = 0;
        while (CE[0] !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        total++;
        if (n != 4) begin
            bad++;
            $display("FAIL acc_cleared_first_ce: got %0d cycles expected 4", n);
        end
    endtask

    task automatic test_lock_glitch();
        int n;
        PLL_LOCK = 1'b0;
        repeat (6) tick();
        total++;
        if (READY !== 1'b0) begin
            bad++;
            $display("FAIL long_drop_ready: got %b expected 0", READY);
        end
        PLL_LOCK = 1'b1;
        tick();
        tick();
        PLL_LOCK = 1'b0;
        tick();
        PLL_LOCK = 1'b1;
        n = 0;
        while (READY !== 1'b1 && n < 30) begin
            tick();
            n++;
        end
        total++;
        if (n != 6) begin
            bad++;
            $display("FAIL glitch_restart: got %0d cycles expected 6", n);
        end
    endtask

    task automatic test_inc_update();
        int n;
        int last;
        int first_gap;
        int pulses;
        int gapbad;
        int c0;
        int c1;
        int c2;
        n = 0;
        while (CE[0] !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        INC_WR = 1'b1;
        INC_CH = 2'd0;
        INC_DATA = 8'd128;
        tick();
        INC_WR = 1'b0;
        last = -1;
        first_gap = -1;
        pulses = 0;
        gapbad = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (CE[0]) begin
                if (last < 0) first_gap = i + 2;
                else if ((i - last) != 2) gapbad++;
                last = i;
                pulses++;
            end
        end
        total++;
        if (first_gap < 2 || first_gap > 4) begin
            bad++;
            $display("FAIL inc_switch_gap: got %0d expected 2..4", first_gap);
        end
        total++;
        if (pulses != 20 || gapbad != 0) begin
            bad++;
            $display("FAIL ch0_period2: got pulses=%0d badgaps=%0d expected pulses=20 badgaps=0", pulses, gapbad);
        end
        INC_WR = 1'b1;
        INC_CH = 2'd3;
        INC_DATA = 8'd1;
        tick();
        INC_WR = 1'b0;
        c0 = 0;
        c1 = 0;
        c2 = 0;
        for (int i = 0; i < 256; i++) begin
            tick();
            if (CE[0]) c0++;
            if (CE[1]) c1++;
            if (CE[2]) c2++;
        end
        total++;
        if (c0 != 128 || c1 != 80 || c2 != 0) begin
            bad++;
            $display("FAIL bad_channel_write: got c0=%0d c1=%0d c2=%0d expected 128 80 0", c0, c1, c2);
        end
    endtask

    task automatic test_zero_full();
        int c2;
        c2 = 0;
        for (int i = 0; i < 1000; i++) begin
            tick();
            if (CE[2]) c2++;
        end
        total++;
        if (c2 != 0) begin
            bad++;
            $display("FAIL inc_zero: got %0d pulses expected 0", c2);
        end
        INC_WR = 1'b1;
        INC_CH = 2'd2;
        INC_DATA = 8'd255;
        tick();
        INC_WR = 1'b0;
        c2 = 0;
        for (int i = 0; i < 256; i++) begin
            tick();
            if (CE[2]) c2++;
        end
        total++;
        if (c2 != 255) begin
            bad++;
            $display("FAIL inc_full: got %0d pulses expected 255", c2);
        end
    endtask

    task automatic test_reset_mid_run();
        int n;
        int c0;
        int c1;
        int c2;
        total++;
        if (READY !== 1'b1) begin
            bad++;
            $display("FAIL pre_reset_run: got READY=%b expected 1", READY);
        end
        RESET = 1'b1;
        INC_WR = 1'b1;
        INC_CH = 2'd0;
        INC_DATA = 8'd200;
        tick();
        RESET = 1'b0;
        INC_WR = 1'b0;
        total++;
        if (READY !== 1'b0 || CE !== 3'b000) begin
            bad++;
            $display("FAIL reset_mid_run: got READY=%b CE=%b expected READY=0 CE=000", READY, CE);
        end
        n = 0;
        while (READY !== 1'b1 && n < 30) begin
            tick();
            n++;
        end
        total++;
        if (n != 6) begin
            bad++;
            $display("FAIL post_reset_latency: got %0d cycles expected 6", n);
        end
        c0 = 0;
        c1 = 0;
        c2 = 0;
        for (int i = 0; i < 256; i++) begin
            tick();
            if (CE[0]) c0++;
            if (CE[1]) c1++;
            if (CE[2]) c2++;
        end
        total++;
        if (c0 != 64 || c1 != 96 || c2 != 0) begin
            bad++;
            $display("FAIL inc_reloaded: got c0=%0d c1=%0d c2=%0d expected 64 96 0", c0, c1, c2);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_lock_ready();
        test_rate_ch1();
        test_lock_drop();
        test_lock_glitch();
        test_inc_update();
        test_zero_full();
        test_reset_mid_run();
        tick();
        tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
